// File: rtl/div_16bit_bcd.sv
// Converts a 16-bit divider quotient to 5 packed BCD digits by shift-add-3
// (double dabble); the remainder is latched on accept and passed through.
module div_16bit_bcd (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] result,
    input  logic [15:0] odd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [19:0] bcd_quo,
    output logic [15:0] odd_out,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q;
    logic [15:0] sr_q;
    logic [15:0] odd_q;
    logic [19:0] acc_q;
    logic [19:0] bcd_q;
    logic [4:0]  cnt_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic        busy_q;
    logic [19:0] acc_adj;
    logic [19:0] acc_d;

    function automatic logic [19:0] add3(input logic [19:0] a);
        logic [19:0] r;
        logic [3:0]  d;
        r = a;
        for (int i = 0; i < 5; i++) begin
            d = a[4*i +: 4];
            if (d >= 4'd5) d = d + 4'd3;
            r[4*i +: 4] = d;
        end
        return r;
    endfunction

    assign acc_adj = add3(acc_q);
    assign acc_d   = {acc_adj[18:0], sr_q[15]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            odd_q       <= '0;
            acc_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sr_q       <= result;
                        odd_q      <= odd;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        state_q    <= SHIFT;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                SHIFT: begin
                    acc_q <= acc_d;
                    sr_q  <= {sr_q[14:0], 1'b0};
                    cnt_q <= cnt_q + 5'd1;
                    // 16th shift: publish the finished digits with out_valid
                    if (cnt_q == 5'd15) begin
                        state_q     <= DONE;
                        bcd_q       <= acc_d;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        bcd_q       <= '0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    bcd_q       <= '0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign bcd_quo   = bcd_q;
    assign odd_out   = odd_q;

endmodule

// File: tb/tb_div_16bit_bcd.sv
// Directed and random checks of div_16bit_bcd against a decimal-digit model.
module tb_div_16bit_bcd;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] result;
    logic [15:0] odd;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] bcd_quo;
    logic [15:0] odd_out;
    logic        busy;

    int n_chk = 0;
    int n_fail = 0;

    div_16bit_bcd dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .result   (result),
        .odd      (odd),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .bcd_quo  (bcd_quo),
        .odd_out  (odd_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] bcd_of(input int v);
        logic [19:0] r;
        int          p;
        r = '0;
        p = 1;
        for (int k = 0; k < 5; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_state(input string tag, input logic [15:0] exp_odd);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_bcd_zero"}, 32'(bcd_quo), 32'd0);
        chk({tag, "_odd_out"}, 32'(odd_out), 32'(exp_odd));
    endtask

    // Accept one operand pair, measure latency, hold DONE for 'hold' cycles
    // with in_valid poked, then consume.
    task automatic do_op(input logic [15:0] r, input logic [15:0] o, input int hold);
        int lat;
        logic [19:0] exp_bcd;
        exp_bcd = bcd_of(int'(r));
        chk("pre_in_ready", 32'(in_ready), 32'd1);
        result = r; odd = o; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        result = ~r; odd = ~o;
        lat = 0;
        chk("shift_bcd_zero", 32'(bcd_quo), 32'd0);
        chk("shift_busy", 32'(busy), 32'd1);
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 5) begin
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("latency", 32'(lat), 32'd16);
        chk("bcd_quo", 32'(bcd_quo), 32'(exp_bcd));
        chk("odd_out", 32'(odd_out), 32'(o));
        chk("done_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_bcd", 32'(bcd_quo), 32'(exp_bcd));
            chk("hold_odd", 32'(odd_out), 32'(o));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        idle_state("consumed", o);
    endtask

    initial begin
        int t1, t2, nv, cyc;
        logic [19:0] b1, b2;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; result = 16'hAAAA; odd = 16'h5555;
        repeat (2) @(negedge clk);
        idle_state("reset", 16'h0000);
        rst = 1'b0;
        @(negedge clk);
        idle_state("post_reset", 16'h0000);

        // out_ready in IDLE does nothing
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        idle_state("idle_out_ready", 16'h0000);

        do_op(16'h0000, 16'h0000, 0);
        do_op(16'hFFFF, 16'h00FE, 1);
        do_op(16'h04D2, 16'h1357, 5);

        // reset during SHIFT discards the operation
        result = 16'd4321; odd = 16'hBEEF; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        idle_state("abort", 16'h0000);
        nv = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        chk("no_stale", 32'(nv), 32'd0);
        do_op(16'd9, 16'h0009, 0);

        // reset during DONE
        result = 16'd777; odd = 16'h0777; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (17) @(negedge clk);
        chk("done_before_rst", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_state("abort_done", 16'h0000);

        // back-to-back with handshakes held high
        result = 16'd100; odd = 16'h0064; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        result = 16'd59999;
        t1 = -1; t2 = -1; nv = 0; b1 = '0; b2 = '0; cyc = 0;
        while (t2 < 0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                nv++;
                if (t1 < 0) begin t1 = cyc; b1 = bcd_quo; end
                else begin t2 = cyc; b2 = bcd_quo; in_valid = 1'b0; end
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        chk("stream_first_lat", 32'(t1), 32'd16);
        chk("stream_period", 32'(t2 - t1), 32'd18);
        chk("stream_pulses", 32'(nv), 32'd2);
        chk("stream_bcd1", 32'(b1), 32'h00100);
        chk("stream_bcd2", 32'(b2), 32'h59999);
        idle_state("stream_end", 16'h0064);

        // random operands against the decimal model
        for (int n = 0; n < 25; n++) begin
            do_op(16'($urandom), 16'($urandom), int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/div_16bit_bcd.md
DIV_16BIT_BCD -- requirements
Module: div_16bit_bcd

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (16-bit quotient and remainder, 5-digit BCD).
REQ-002 clk  input  1  rising-edge clock; all state changes on this edge only.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  upstream divider result available on result/odd.
REQ-005 in_ready  output  1  block can accept a new divider result.
REQ-006 result  input  16  unsigned quotient from the 16-bit divider stage.
REQ-007 odd  input  16  unsigned remainder from the 16-bit divider stage.
REQ-008 out_valid  output  1  bcd_quo/odd_out hold a completed conversion.
REQ-009 out_ready  input  1  downstream consumes the output.
REQ-010 bcd_quo  output  20  quotient as 5 packed BCD digits; [19:16] is ten-thousands, [3:0] is units.
REQ-011 odd_out  output  16  remainder captured with the quotient, passed through unchanged.
REQ-012 busy  output  1  high in SHIFT and DONE states.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, SHIFT and DONE; the encoding is free.
REQ-014 IDLE: in_ready=1, out_valid=0; the block SHALL accept on a clk edge where in_valid=1 and in_ready=1, then go to SHIFT.
REQ-015 On accept, the block SHALL load result into a 16-bit shift register, latch odd into odd_out, clear the 20-bit BCD accumulator and set a 5-bit shift counter to 0.
REQ-016 SHIFT: each cycle, every BCD digit SHALL first get +3 if its value is 5..9; the accumulator SHALL then shift left 1 bit, taking in the shift register MSB, and the shift register SHALL shift left 1 bit.
REQ-017 SHIFT SHALL last exactly 16 cycles; after the 16th shift edge the state SHALL be DONE.
REQ-018 Latency: out_valid SHALL rise exactly 16 clk edges after the accept edge.
REQ-019 DONE: out_valid=1; bcd_quo and odd_out SHALL stay stable until the edge where out_ready=1; on that edge the FSM SHALL return to IDLE.
REQ-020 in_ready SHALL be 0 in SHIFT and DONE; in_valid SHALL be ignored there, with no capture and no corruption of the operation in flight.
REQ-021 There SHALL be no overlap between operations: the minimum accept-to-accept period is 18 cycles (1 accept, 16 SHIFT, 1 DONE with out_ready=1).
REQ-022 The final digits SHALL each be 0..9; the maximum input 0xFFFF SHALL give bcd_quo=0x65535, and digit [19:16] SHALL never exceed 6.
REQ-023 bcd_quo SHALL show the accumulator only in DONE and SHALL read 0 otherwise; odd_out SHALL hold its last latched value until the next accept or reset.
REQ-024 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-025 While rst=1 at a clk edge: state=IDLE, in_ready=1, out_valid=0, busy=0, bcd_quo=0, odd_out=0, and the shift register and counter are cleared.
REQ-026 Reset asserted in SHIFT or DONE SHALL abort the operation; the in-flight result SHALL be discarded and never presented.
REQ-027 rst SHALL take priority over in_valid and out_ready on the same edge.
REQ-028 in_ready SHALL be 1 on the first cycle after rst is released.

Verification
REQ-029 result=0x0000, odd=0x0000 -> out_valid 16 edges after accept, bcd_quo=0x00000, odd_out=0x0000.
REQ-030 result=0xFFFF, odd=0x00FE -> bcd_quo=0x65535, odd_out=0x00FE.
REQ-031 result=0x04D2 (1234), out_ready held 0 for 5 cycles in DONE with in_valid pulsed -> bcd_quo=0x01234 stable, in_ready=0, no new capture.
REQ-032 rst=1 on the 8th SHIFT cycle -> next cycle out_valid=0, in_ready=1, bcd_quo=0; then result=9 -> bcd_quo=0x00009, and no stale result ever appears.
REQ-033 in_valid=1 and out_ready=1 held, inputs 100 then 59999 -> out_valid pulses 1 cycle each, 18 cycles apart, bcd_quo=0x00100 then 0x59999.
